rca4_serial_ctrl: RTL and testbench
===================================

Name: rca4_serial_ctrl

Overview:
- Sequencer that adds two NIBBLES*4-bit operands by time-multiplexing one rca4 (4-bit ripple-carry adder: a[3:0], b[3:0], cin, sum[4:0]).
- Processes one nibble per cycle, least significant first.
- Carries between nibbles through an internal carry register.
- Accepts operands and returns results over valid/ready handshakes.
- Sits between an operand source and a result consumer. It is the sole owner of its rca4 instance.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand (operand width W = 4*NIBBLES); legal range 1..16.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  controller can accept operands.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry-in to nibble 0.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  W+1  result; bit W is the final carry-out.
- busy  output  1  high in RUN or DONE.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high; all state updates on the rising edge of clk.
- Reset values:
  - state=IDLE, out_valid=0, sum=0, busy=0.
  - Internal carry, nibble index and operand registers all 0.
  - in_ready=0 while reset is high.
- in_ready = (state==IDLE) & ~reset. It is combinational from state only, with no path from in_valid.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready:
    - Capture a, b and cin into internal registers.
    - Set idx=0, clear the sum register.
    - Next state RUN.
  - RUN: each cycle, drive rca4 with a_r[4*idx+:4], b_r[4*idx+:4] and carry_r, then:
    - Write the rca4 sum[3:0] into sum_r[4*idx+:4].
    - carry_r <= rca4 sum[4].
    - idx <= idx+1.
    - When idx==NIBBLES-1, also write sum_r[W] = rca4 sum[4] and go to DONE.
  - DONE: out_valid=1 and sum holds the final value. When out_ready is high on a clock edge, go to IDLE and clear out_valid.
- Latency:
  - The handshake edge enters RUN.
  - Exactly NIBBLES RUN cycles follow.
  - out_valid rises on the edge that ends the last RUN cycle.
  - For NIBBLES=4: 4 cycles from acceptance to out_valid.
  - Minimum acceptance-to-acceptance interval is NIBBLES+2 cycles with out_ready held high.
- sum output:
  - Stable while out_valid=1. It is not guaranteed meaningful outside DONE, but must never change while out_valid=1.
  - After DONE->IDLE, sum keeps its last value until the next acceptance clears it.
- Back-pressure: out_ready low holds DONE indefinitely. No new operands are accepted, and sum and out_valid stay frozen.
- Operand stability: a, b and cin are sampled only at the handshake. Changes during RUN or DONE have no effect, and in_valid outside IDLE is ignored.
- Width rule: the result equals a + b + cin modulo 2^(W+1), which is always exact.
- idx wrap: idx is $clog2(NIBBLES)+1 bits wide, is reset to 0 on acceptance and never wraps in RUN. For NIBBLES=1, RUN lasts one cycle.
- Reset mid-operation (RUN or DONE):
  - Abort the operation and go to IDLE.
  - out_valid=0 and sum=0 on the next edge.
  - The partial result is discarded and no out_valid pulse is produced.
- Simultaneous events: reset has priority over in_valid and out_ready on the same edge.
- The rca4 is purely combinational. Its inputs are driven to 0 when not in RUN, so it does not toggle in idle.

Test Plan:
- NIBBLES=4, a=16'h1234, b=16'h4321, cin=1, out_ready=1 -> out_valid exactly 4 cycles after acceptance, sum=17'h05556, out_valid high for 1 cycle.
- a=16'hFFFF, b=16'h0001, cin=0 -> carry ripples through all 4 nibbles, sum=17'h10000. Then a=16'h0FFF, b=16'h0001, cin=0 -> sum=17'h01000.
- out_ready held low 5 cycles after out_valid -> sum and out_valid stable, in_ready=0, in_valid pulses ignored. On out_ready=1: IDLE next cycle, in_ready=1.
- Change a/b every cycle during RUN -> result reflects only the values captured at acceptance (a=16'hAAAA, b=16'h5555, cin=1 -> 17'h10000).
- Assert reset in the 2nd RUN cycle -> next edge: out_valid=0, sum=0, in_ready=1 after reset drops, no stale result. A new operation completes correctly.
- NIBBLES=1 build, 150 random a/b/cin with out_ready=1 -> every sum equals a+b+cin (5 bits), 1-cycle RUN latency, error count 0.

Source files
------------

// File: rtl/rca4_serial_ctrl.sv
// rtl/rca4_serial_ctrl.sv - nibble-serial adder sequencer around a shared 4-bit ripple-carry adder

// 4-bit ripple-carry adder, purely combinational
module rca4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [4:0] o_sum
);

  logic [4:0] w_c;

  assign w_c[0] = i_cin;

  genvar g;
  for (g = 0; g < 4; g++) begin : g_fa
    assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_sum[4] = w_c[4];

endmodule

// Sequencer: captures a W-bit operand pair, then adds one nibble per cycle
// (LSB first) through a single rca4, chaining the carry in r_carry.
module rca4_serial_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [4*NIBBLES-1:0] i_a,
  input  logic [4*NIBBLES-1:0] i_b,
  input  logic                 i_cin,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [4*NIBBLES:0]   o_sum,
  output logic                 o_busy
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = $clog2(NIBBLES) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic              r_carry;
  logic [IDXW-1:0]   r_idx;
  logic [W:0]        r_sum;

  logic [3:0]        w_nib_a;
  logic [3:0]        w_nib_b;
  logic              w_nib_c;
  logic [4:0]        w_rca_sum;
  logic              w_last;
  logic              w_accept;

  assign w_last   = (r_idx == IDXW'(NIBBLES - 1));
  assign w_accept = (r_state == S_IDLE) && i_in_valid;
  assign o_sum    = r_sum;

  // Select the active nibble for the adder; inputs held at zero outside RUN so it stays quiet
  always_comb begin
    w_nib_a = 4'd0;
    w_nib_b = 4'd0;
    w_nib_c = 1'b0;
    if (r_state == S_RUN) begin
      w_nib_c = r_carry;
      for (int n = 0; n < NIBBLES; n++) begin
        if (r_idx == IDXW'(n)) begin
          w_nib_a = r_a[4*n +: 4];
          w_nib_b = r_b[4*n +: 4];
        end
      end
    end
  end

  rca4 u_rca4 (
    .i_a   (w_nib_a),
    .i_b   (w_nib_b),
    .i_cin (w_nib_c),
    .o_sum (w_rca_sum)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake outputs; in_ready depends only on state and reset
  always_comb begin
    w_next_state = r_state;
    o_in_ready   = 1'b0;
    o_out_valid  = 1'b0;
    o_busy       = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_in_ready = ~i_reset;
        if (i_in_valid) begin
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        o_busy = 1'b1;
        if (w_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        o_busy      = 1'b1;
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Operand capture on acceptance, then one nibble of sum and carry per RUN cycle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
    end else if (w_accept) begin
      r_a     <= i_a;
      r_b     <= i_b;
      r_carry <= i_cin;
      r_idx   <= '0;
      r_sum   <= '0;
    end else if (r_state == S_RUN) begin
      for (int n = 0; n < NIBBLES; n++) begin
        if (r_idx == IDXW'(n)) begin
          r_sum[4*n +: 4] <= w_rca_sum[3:0];
        end
      end
      if (w_last) begin
        r_sum[W] <= w_rca_sum[4];
      end
      r_carry <= w_rca_sum[4];
      r_idx   <= r_idx + IDXW'(1);
    end
  end

endmodule

// File: tb/tb_rca4_serial_ctrl.sv
// tb/tb_rca4_serial_ctrl.sv - self-checking bench for rca4_serial_ctrl (NIBBLES=4 and NIBBLES=1)
module tb_rca4_serial_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;

  logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4, busy4;
  logic [15:0] a4, b4;
  logic [16:0] sum4;

  logic        in_valid1, in_ready1, cin1, out_valid1, out_ready1, busy1;
  logic [3:0]  a1, b1;
  logic [4:0]  sum1;

  int n_checks = 0;
  int n_errors = 0;

  rca4_serial_ctrl #(.NIBBLES(4)) dut4 (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_in_valid  (in_valid4),
    .o_in_ready  (in_ready4),
    .i_a         (a4),
    .i_b         (b4),
    .i_cin       (cin4),
    .o_out_valid (out_valid4),
    .i_out_ready (out_ready4),
    .o_sum       (sum4),
    .o_busy      (busy4)
  );

  rca4_serial_ctrl #(.NIBBLES(1)) dut1 (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_in_valid  (in_valid1),
    .o_in_ready  (in_ready1),
    .i_a         (a1),
    .i_b         (b1),
    .i_cin       (cin1),
    .o_out_valid (out_valid1),
    .i_out_ready (out_ready1),
    .o_sum       (sum1),
    .o_busy      (busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the 4-nibble instance; hold = cycles of out_ready low after out_valid
  task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic c, input int hold);
    logic [16:0] exp;
    int          cyc;
    exp = 17'(a) + 17'(b) + 17'(c);
    cyc = 0;
    while (!in_ready4 && cyc < 20) begin
      step;
      cyc++;
    end
    check("in_ready_before_accept", 32'(in_ready4), 32'd1);
    a4 = a; b4 = b; cin4 = c; in_valid4 = 1'b1;
    out_ready4 = (hold == 0);
    step;
    check("busy_in_run", 32'(busy4), 32'd1);
    check("in_ready_in_run", 32'(in_ready4), 32'd0);
    cyc = 0;
    while (!out_valid4 && cyc < 20) begin
      a4 = 16'($urandom); b4 = 16'($urandom); cin4 = 1'($urandom);
      in_valid4 = 1'($urandom);
      step;
      cyc++;
    end
    in_valid4 = 1'b0;
    check("latency", 32'(cyc), 32'd4);
    check("sum", 32'(sum4), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      in_valid4 = 1'($urandom);
      a4 = 16'($urandom);
      step;
      check("hold_out_valid", 32'(out_valid4), 32'd1);
      check("hold_sum", 32'(sum4), 32'(exp));
      check("hold_in_ready", 32'(in_ready4), 32'd0);
    end
    in_valid4 = 1'b0;
    out_ready4 = 1'b1;
    step;
    check("out_valid_drop", 32'(out_valid4), 32'd0);
    check("in_ready_after_done", 32'(in_ready4), 32'd1);
    check("sum_kept_after_done", 32'(sum4), 32'(exp));
  endtask

  initial begin
    logic [4:0] exp1;

    reset = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; out_ready4 = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;
    step; step; step;
    check("rst_out_valid", 32'(out_valid4), 32'd0);
    check("rst_sum", 32'(sum4), 32'd0);
    check("rst_in_ready", 32'(in_ready4), 32'd0);
    check("rst_busy", 32'(busy4), 32'd0);
    reset = 1'b0;
    #1;
    check("in_ready_after_rst", 32'(in_ready4), 32'd1);

    op4(16'h1234, 16'h4321, 1'b1, 0);
    op4(16'hFFFF, 16'h0001, 1'b0, 0);
    op4(16'h0FFF, 16'h0001, 1'b0, 0);
    op4(16'h1234, 16'h4321, 1'b1, 5);
    op4(16'hAAAA, 16'h5555, 1'b1, 0);

    // Abort in the second RUN cycle
    a4 = 16'h1111; b4 = 16'h2222; cin4 = 1'b0; in_valid4 = 1'b1;
    step;
    in_valid4 = 1'b0;
    step;
    reset = 1'b1;
    step;
    check("abort_out_valid", 32'(out_valid4), 32'd0);
    check("abort_sum", 32'(sum4), 32'd0);
    check("abort_in_ready_in_rst", 32'(in_ready4), 32'd0);
    check("abort_busy", 32'(busy4), 32'd0);
    reset = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready4), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step;
      check("abort_no_stale_valid", 32'(out_valid4), 32'd0);
    end
    op4(16'h0F0F, 16'h00F1, 1'b1, 0);

    for (int i = 0; i < 20; i++) begin
      op4(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    // Single-nibble build: one RUN cycle per operation
    for (int i = 0; i < 150; i++) begin
      a1 = 4'($urandom); b1 = 4'($urandom); cin1 = 1'($urandom);
      exp1 = 5'(a1) + 5'(b1) + 5'(cin1);
      check("n1_in_ready", 32'(in_ready1), 32'd1);
      in_valid1 = 1'b1;
      step;
      in_valid1 = 1'b0;
      a1 = 4'($urandom); b1 = 4'($urandom); cin1 = 1'($urandom);
      step;
      check("n1_out_valid", 32'(out_valid1), 32'd1);
      check("n1_sum", 32'(sum1), 32'(exp1));
      step;
      check("n1_out_valid_drop", 32'(out_valid1), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
